dram_arb: RTL

- Two-port arbiter in front of the single-port data RAM.
- Shares the RAM between the CPU load/store port (m0) and the external loader/debug port (m1).
- Round-robin arbitration with an optional bounded lock for m1 bursts. Read data returns after a fixed latency and is steered to the port that issued the read.
- Sits between the CPU memory stage (driven by dram_wr_en / if_load_inst from decode) and the RAM macro. It also produces the CPU stall.

---
 rtl/dram_arb_pkg.sv | 17 +
 rtl/dram_rsp_tag.sv | 31 +++
 rtl/dram_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// Shared constants and helpers for the data-RAM arbiter.
package dram_arb_pkg;
  localparam int DRAM_ADDR_W = 14;
  localparam int DRAM_DATA_W = 32;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_LOCK1 = 1'b1
  } arb_st_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction
endpackage

// File: rtl/dram_rsp_tag.sv
// RD_LAT-deep {valid, id} pipe that steers read data back to the issuing port.
module dram_rsp_tag #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  output logic pop,
  output logic pop_id
);
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] id_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= push;
      id_pipe[0]  <= push_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign pop    = vld_pipe[RD_LAT-1];
  assign pop_id = id_pipe[RD_LAT-1];
endmodule

// File: rtl/dram_arb.sv
// Round-robin CPU/loader arbiter for the single-port data RAM with bounded m1 burst lock.
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int ADDR_W   = DRAM_ADDR_W,
  parameter int DATA_W   = DRAM_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_valid,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                cpu_stall,
  input  logic                m1_valid,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_lock,
  output logic                m1_ready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);
  localparam int SW = DATA_W / 8;
  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     wstrb;
  } req_t;

  req_t req0, req1, sel;
  arb_st_e state, state_nxt;
  logic prio, prio_nxt;
  logic [7:0] lock_cnt, cnt_nxt, cnt_inc;
  logic gnt0, gnt1;
  logic rsp_vld, rsp_id;

  assign req0 = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign req1 = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = lock_cnt;
    cnt_inc   = sat_inc(lock_cnt, LOCK_MAX);
    if (rst_n) begin
      if (state == ST_LOCK1) begin
        // a saturated lock yields to a waiting m0 even if m1 still wants the bus
        if (m1_valid && !(lock_cnt >= LOCK_MAX && m0_valid)) gnt1 = 1'b1;
        else                                                  gnt0 = m0_valid;
      end else begin
        if (m0_valid && (!m1_valid || prio == ARB_M0)) gnt0 = 1'b1;
        else                                           gnt1 = m1_valid;
      end
    end
    if (gnt0) begin
      prio_nxt  = ARB_M1;
      state_nxt = ST_ARB;
      cnt_nxt   = '0;
    end else if (gnt1) begin
      prio_nxt = ARB_M0;
      if (!m1_lock) begin
        state_nxt = ST_ARB;
        cnt_nxt   = '0;
      end else if (state == ST_ARB) begin
        state_nxt = ST_LOCK1;
        cnt_nxt   = 8'd1;
      end else if (cnt_inc >= LOCK_MAX && m0_valid) begin
        state_nxt = ST_ARB;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_inc;
      end
    end else if (state == ST_LOCK1 && !m1_valid) begin
      state_nxt = ST_ARB;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ARB;
      prio     <= ARB_M0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  assign sel       = gnt1 ? req1 : req0;
  assign ram_en    = gnt0 | gnt1;
  assign ram_we    = (ram_en && sel.we) ? sel.wstrb : '0;
  assign ram_addr  = ram_en ? sel.addr : '0;
  assign ram_wdata = (ram_en && sel.we) ? sel.wdata : '0;

  assign m0_ready  = gnt0;
  assign m1_ready  = gnt1;
  assign cpu_stall = rst_n & m0_valid & ~gnt0;

  dram_rsp_tag #(.RD_LAT(RD_LAT)) u_tag (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ram_en & ~sel.we),
    .push_id (gnt1),
    .pop     (rsp_vld),
    .pop_id  (rsp_id)
  );

  assign m0_rvalid = rsp_vld & (rsp_id == ARB_M0);
  assign m1_rvalid = rsp_vld & (rsp_id == ARB_M1);
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;
endmodule
